// File: rtl/hgcal_input_quantizer_packer.sv
// Quantizes a valid/ready stream of unsigned charge samples to 2-bit codes and packs one frame
// into a flat registered bus for the layer0 neuron LUTs. Double-buffered: assembly plus output register.
module hgcal_input_quantizer_packer #(
  parameter int NUM_INPUTS = 16,
  parameter int IN_WIDTH   = 10,
  parameter int T1         = 64,
  parameter int T2         = 256,
  parameter int T3         = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [IN_WIDTH-1:0]       s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [NUM_INPUTS*2-1:0]   m_data,
  output logic                      err_len
);

  localparam int OUT_W = NUM_INPUTS * 2;
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_INPUTS - 1);
  localparam logic [IN_WIDTH-1:0] T1_C     = IN_WIDTH'(T1);
  localparam logic [IN_WIDTH-1:0] T2_C     = IN_WIDTH'(T2);
  localparam logic [IN_WIDTH-1:0] T3_C     = IN_WIDTH'(T3);

  if (!((T1 <= T2) && (T2 <= T3))) begin : g_thr_order
    $error("thresholds must satisfy T1 <= T2 <= T3");
  end

  typedef enum logic [1:0] {FILL, HOLD, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   asm_q, asm_d;
  logic               m_valid_q, m_valid_d;
  logic [OUT_W-1:0]   m_data_q, m_data_d;
  logic               err_q, err_d;
  logic               pend_q, pend_d;

  logic               accept;
  logic               out_free;
  logic [1:0]         code;
  logic [OUT_W-1:0]   asm_wr;

  function automatic logic [1:0] quantize(input logic [IN_WIDTH-1:0] d);
    logic [1:0] c;
    c = 2'd0;
    if (d >= T1_C) c = c + 2'd1;
    if (d >= T2_C) c = c + 2'd1;
    if (d >= T3_C) c = c + 2'd1;
    return c;
  endfunction

  assign s_ready  = rst && (state_q != HOLD);
  assign accept   = s_valid && s_ready;
  assign out_free = !m_valid_q || m_ready;
  assign code     = quantize(s_data);

  always_comb begin
    asm_wr = asm_q;
    asm_wr[{idx_q, 1'b0} +: 2] = code;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    err_d     = 1'b0;
    pend_d    = pend_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            err_d = !s_last;
            if (out_free) begin
              m_data_d  = asm_wr;
              m_valid_d = 1'b1;
              asm_d     = '0;
              state_d   = s_last ? FILL : DRAIN;
            end else begin
              // Output still occupied: park the completed frame and stop taking input.
              asm_d   = asm_wr;
              pend_d  = !s_last;
              state_d = HOLD;
            end
          end else if (s_last) begin
            idx_d = '0;
            asm_d = '0;
            err_d = 1'b1;
          end else begin
            asm_d = asm_wr;
            idx_d = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          m_data_d  = asm_q;
          m_valid_d = 1'b1;
          asm_d     = '0;
          pend_d    = 1'b0;
          state_d   = pend_q ? DRAIN : FILL;
        end
      end
      DRAIN: begin
        if (accept && s_last) begin
          idx_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FILL;
      idx_q     <= '0;
      asm_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign err_len = err_q;

endmodule

// File: tb/tb_hgcal_input_quantizer_packer.sv
// Directed bench for hgcal_input_quantizer_packer: expected frames are queued at stimulus time
// and a separate monitor pops and compares them on every output transfer.
module tb_hgcal_input_quantizer_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [9:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        err_len;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int err_seen = 0;
  logic [31:0] exp_q[$];
  logic [9:0]  fr[16];

  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [31:0] prev_d = '0;

  hgcal_input_quantizer_packer #(
    .NUM_INPUTS(16), .IN_WIDTH(10), .T1(64), .T2(256), .T3(512)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err_len(err_len)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] qref(input logic [9:0] d);
    if (d >= 10'd512) return 2'd3;
    if (d >= 10'd256) return 2'd2;
    if (d >= 10'd64)  return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] pack_fr();
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) w[2*k +: 2] = qref(fr[k]);
    return w;
  endfunction

  // Drives one sample and returns #1 after the edge that accepts it.
  task automatic send(input logic [9:0] d, input logic last);
    int n;
    logic rdy;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      errors++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
    if (n > 1) stalls++;
  endtask

  task automatic send_fr(input logic last_on_16);
    for (int k = 0; k < 16; k++) send(fr[k], (k == 15) && last_on_16);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (prev_v === 1'b1 && prev_r === 1'b0) begin
      chk("hold_valid", {31'd0, m_valid}, 32'd1);
      chk("hold_data", m_data, prev_d);
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame actual=%h required=none", m_data);
      end else begin
        e = exp_q.pop_front();
        chk("frame_data", m_data, e);
      end
    end
    if (err_len === 1'b1) err_seen++;
    prev_v = m_valid;
    prev_r = m_ready;
    prev_d = m_data;
  end

  initial begin
    // Reset held with traffic offered
    rst = 1'b0;
    s_valid = 1'b1;
    s_data = 10'd700;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_err_len", {31'd0, err_len}, 32'd0);
    rst = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;

    // Threshold edges, both halves identical
    fr = '{10'd0, 10'd63, 10'd64, 10'd255, 10'd256, 10'd511, 10'd512, 10'd1023,
           10'd0, 10'd63, 10'd64, 10'd255, 10'd256, 10'd511, 10'd512, 10'd1023};
    exp_q.push_back(32'hFA50FA50);
    send_fr(1'b1);
    chk("q_latency_valid", {31'd0, m_valid}, 32'd1);
    chk("q_data", m_data, 32'hFA50FA50);
    idle(2);

    // Back-to-back frames at full throughput
    stalls = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++) fr[k] = 10'((f * 97 + k * 131 + 5) % 1024);
      exp_q.push_back(pack_fr());
      send_fr(1'b1);
      chk("b2b_valid", {31'd0, m_valid}, 32'd1);
      if (f < 2) begin
        send(10'((f * 97 + 16 * 131 + 5) % 1024), 1'b0);
        chk("b2b_valid_drop", {31'd0, m_valid}, 32'd0);
        // re-send sample 0 of next frame is already in; rebuild frame from index 1
        for (int k = 0; k < 16; k++) fr[k] = 10'(((f + 1) * 97 + k * 131 + 5) % 1024);
        fr[0] = 10'((f * 97 + 16 * 131 + 5) % 1024);
        exp_q.push_back(pack_fr());
        for (int k = 1; k < 16; k++) send(fr[k], k == 15);
        chk("b2b_valid2", {31'd0, m_valid}, 32'd1);
      end
    end
    chk("b2b_no_stall", stalls, 0);
    idle(3);

    // Output stall with two frames
    m_ready = 1'b0;
    stalls = 0;
    for (int k = 0; k < 16; k++) fr[k] = 10'((k * 67 + 300) % 1024);
    exp_q.push_back(pack_fr());
    send_fr(1'b1);
    chk("stall_a_valid", {31'd0, m_valid}, 32'd1);
    chk("stall_a_data", m_data, exp_q[0]);
    for (int k = 0; k < 16; k++) fr[k] = 10'((1023 - k * 61) % 1024);
    exp_q.push_back(pack_fr());
    send_fr(1'b1);
    chk("stall_accepts", stalls, 0);
    chk("stall_s_ready_low", {31'd0, s_ready}, 32'd0);
    chk("stall_hold_a", m_data, exp_q[0]);
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk("stall_b_valid", {31'd0, m_valid}, 32'd1);
    chk("stall_b_data", m_data, exp_q[0]);
    chk("stall_s_ready_back", {31'd0, s_ready}, 32'd1);
    m_ready = 1'b1;
    idle(3);

    // Short frame: last on 5th sample
    for (int k = 0; k < 5; k++) send(10'd1023, k == 4);
    chk("short_err", {31'd0, err_len}, 32'd1);
    chk("short_no_valid", {31'd0, m_valid}, 32'd0);
    idle(1);
    chk("short_err_once", {31'd0, err_len}, 32'd0);
    for (int k = 0; k < 16; k++) fr[k] = (k % 4 == 0) ? 10'd70 : 10'd0;
    exp_q.push_back(32'h01010101);
    send_fr(1'b1);
    chk("short_next_data", m_data, 32'h01010101);
    idle(3);

    // Long frame: 20 samples, last on 20th
    for (int k = 0; k < 16; k++) fr[k] = 10'((k * 211 + 40) % 1024);
    exp_q.push_back(pack_fr());
    send_fr(1'b0);
    chk("long_valid", {31'd0, m_valid}, 32'd1);
    chk("long_err", {31'd0, err_len}, 32'd1);
    chk("long_data", m_data, pack_fr());
    send(10'd900, 1'b0);
    chk("long_err_once", {31'd0, err_len}, 32'd0);
    send(10'd900, 1'b0);
    send(10'd900, 1'b0);
    send(10'd900, 1'b1);
    chk("long_drain_valid", {31'd0, m_valid}, 32'd0);

    // Reset mid-frame after 7 samples
    for (int k = 0; k < 7; k++) send(10'd600, 1'b0);
    rst = 1'b0;
    s_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mrst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("mrst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mrst_m_data", m_data, 32'd0);
    chk("mrst_err_len", {31'd0, err_len}, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 16; k++) fr[k] = (k < 8) ? 10'd0 : 10'd300;
    exp_q.push_back(32'hAAAA0000);
    send_fr(1'b1);
    chk("mrst_next_data", m_data, 32'hAAAA0000);
    idle(4);

    chk("queue_empty", exp_q.size(), 0);
    chk("err_pulses", err_seen, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
